// File: rtl/clock_monitor.sv
// Frequency-window monitor for an asynchronous clock: measures each half-period
// in sampling-clock cycles, locks after LOCK_EDGES good measurements, flags faults.
module clock_monitor #(
   parameter int unsigned CNT_W      = 8,
   parameter int unsigned MIN_HALF   = 4,
   parameter int unsigned MAX_HALF   = 12,
   parameter int unsigned LOCK_EDGES = 4,
   parameter int unsigned LOST_LIMIT = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             mon_clock,
   input  logic             fault_clear,
   output logic             locked,
   output logic             fault,
   output logic             lost,
   output logic [CNT_W-1:0] half_period
);

   localparam int unsigned GOOD_W = $clog2(LOCK_EDGES + 1);
   localparam logic [CNT_W-1:0]  MIN_C   = CNT_W'(MIN_HALF);
   localparam logic [CNT_W-1:0]  MAX_C   = CNT_W'(MAX_HALF);
   localparam logic [CNT_W-1:0]  LOST_C  = CNT_W'(LOST_LIMIT);
   localparam logic [CNT_W-1:0]  CNT_MAX = '1;
   localparam logic [GOOD_W-1:0] LOCK_C  = GOOD_W'(LOCK_EDGES);

   typedef enum logic [1:0] {ST_IDLE, ST_ACQUIRE, ST_LOCKED, ST_FAULT} state_t;

   state_t            state_q, state_d;
   logic [2:0]        sync_q, sync_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  hp_q, hp_d;
   logic [GOOD_W-1:0] good_q, good_d;
   logic              discard_q, discard_d;
   logic              locked_q, locked_d;
   logic              fault_q, fault_d;
   logic              lost_q, lost_d;

   logic [CNT_W-1:0]  meas;
   logic [GOOD_W-1:0] good_inc;
   logic              mon_edge, active, measured, in_win, timeout;

   // sync_q[1] is the second synchronizer stage, sync_q[2] the edge-detect stage
   always_comb begin
      sync_d   = {sync_q[1:0], mon_clock};
      mon_edge = sync_q[1] ^ sync_q[2];
      meas     = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
      in_win   = (meas >= MIN_C) && (meas <= MAX_C);
      active   = (state_q == ST_ACQUIRE) || (state_q == ST_LOCKED);
      measured = active && mon_edge && !discard_q;
      timeout  = active && !mon_edge && (cnt_q >= LOST_C);
      good_inc = good_q + 1'b1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (!enable) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:    state_d = ST_ACQUIRE;
            ST_ACQUIRE: begin
               if (measured && in_win && (good_inc == LOCK_C)) state_d = ST_LOCKED;
               else if (timeout)                                state_d = ST_FAULT;
            end
            ST_LOCKED: begin
               if ((measured && !in_win) || timeout) state_d = ST_FAULT;
            end
            ST_FAULT: begin
               if (fault_clear) state_d = ST_ACQUIRE;
            end
            default:    state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      locked_d = (state_d == ST_LOCKED);
      fault_d  = (state_d == ST_FAULT);
      lost_d   = 1'b0;
      if (state_d == ST_FAULT) begin
         // an out-of-window edge can never coincide with a timeout, so the cause is unambiguous
         lost_d = (state_q == ST_FAULT) ? lost_q : timeout;
      end
   end

   always_comb begin
      cnt_d     = cnt_q;
      good_d    = good_q;
      discard_d = discard_q;
      hp_d      = hp_q;

      if (!enable || (state_q == ST_IDLE) || (state_q == ST_FAULT && fault_clear)) begin
         cnt_d = '0;
      end else if (mon_edge) begin
         cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + 1'b1;
      end

      if (state_d != ST_ACQUIRE) begin
         good_d = '0;
      end else if (state_q == ST_ACQUIRE && measured) begin
         good_d = in_win ? good_inc : '0;
      end

      if (state_d == ST_ACQUIRE && state_q != ST_ACQUIRE) begin
         discard_d = 1'b1;
      end else if (state_q == ST_ACQUIRE && mon_edge) begin
         discard_d = 1'b0;
      end

      if (enable && measured) hp_d = meas;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_q    <= '0;
         cnt_q     <= '0;
         good_q    <= '0;
         discard_q <= 1'b0;
         hp_q      <= '0;
         locked_q  <= 1'b0;
         fault_q   <= 1'b0;
         lost_q    <= 1'b0;
      end else begin
         sync_q    <= sync_d;
         cnt_q     <= cnt_d;
         good_q    <= good_d;
         discard_q <= discard_d;
         hp_q      <= hp_d;
         locked_q  <= locked_d;
         fault_q   <= fault_d;
         lost_q    <= lost_d;
      end
   end

   assign locked      = locked_q;
   assign fault       = fault_q;
   assign lost        = lost_q;
   assign half_period = hp_q;

endmodule

// File: tb/tb_clock_monitor.sv
// Bench for clock_monitor: directed scenarios, cycle-by-cycle comparison against
// a behavioural model, plus literal expectations at key points.
module tb_clock_monitor;

   localparam int unsigned CNT_W      = 8;
   localparam int unsigned MIN_HALF   = 4;
   localparam int unsigned MAX_HALF   = 12;
   localparam int unsigned LOCK_EDGES = 4;
   localparam int unsigned LOST_LIMIT = 32;
   localparam int          SAT        = (1 << CNT_W) - 1;

   logic             clock = 1'b0;
   logic             reset;
   logic             enable;
   logic             mon_clock = 1'b0;
   logic             fault_clear;
   logic             locked, fault, lost;
   logic [CNT_W-1:0] half_period;

   int n_checks = 0;
   int n_errors = 0;

   clock_monitor #(
      .CNT_W(CNT_W), .MIN_HALF(MIN_HALF), .MAX_HALF(MAX_HALF),
      .LOCK_EDGES(LOCK_EDGES), .LOST_LIMIT(LOST_LIMIT)
   ) dut (
      .clock(clock), .reset(reset), .enable(enable), .mon_clock(mon_clock),
      .fault_clear(fault_clear), .locked(locked), .fault(fault), .lost(lost),
      .half_period(half_period)
   );

   always #5 clock = ~clock;

   // monitored clock: toggles every mon_half sampling cycles, stopped when 0
   int mon_half = 8;
   int ph = 0;
   always @(negedge clock) begin
      if (mon_half > 0) begin
         ph++;
         if (ph >= mon_half) begin
            mon_clock = ~mon_clock;
            ph = 0;
         end
      end
   end

   // behavioural model: mode 0 idle, 1 acquiring, 2 locked, 3 fault
   int md, since, good, lost_f, hp_m, meas;
   bit discard, ev, ok;
   bit hist[$];

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         md = 0; since = 0; good = 0; lost_f = 0; hp_m = 0; discard = 0;
         hist = '{1'b0, 1'b0, 1'b0};
      end else begin
         // a level change is seen when the samples taken 2 and 3 clocks ago differ
         ev = (hist[1] != hist[2]);
         hist.push_front(mon_clock);
         void'(hist.pop_back());
         if (!enable) begin
            md = 0; since = 0; good = 0; lost_f = 0;
         end else if (md == 0) begin
            md = 1; since = 0; good = 0; discard = 1;
         end else if (md == 3) begin
            if (fault_clear) begin
               md = 1; since = 0; good = 0; discard = 1; lost_f = 0;
            end else begin
               since = ev ? 0 : ((since + 1 > SAT) ? SAT : since + 1);
            end
         end else if (ev) begin
            if (discard) begin
               discard = 0;
            end else begin
               meas = (since + 1 > SAT) ? SAT : since + 1;
               hp_m = meas;
               ok = (meas >= int'(MIN_HALF)) && (meas <= int'(MAX_HALF));
               if (md == 1) begin
                  good = ok ? good + 1 : 0;
                  if (good >= int'(LOCK_EDGES)) begin
                     md = 2; good = 0;
                  end
               end else if (!ok) begin
                  md = 3; lost_f = 0;
               end
            end
            since = 0;
         end else begin
            if (since >= int'(LOST_LIMIT)) begin
               md = 3; lost_f = 1;
            end
            since = (since + 1 > SAT) ? SAT : since + 1;
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      if (!reset) begin
         chk("model_locked", int'(locked), (md == 2) ? 1 : 0);
         chk("model_fault",  int'(fault),  (md == 3) ? 1 : 0);
         chk("model_lost",   int'(lost),   (md == 3) ? lost_f : 0);
         chk("model_half",   int'(half_period), hp_m);
      end
   end

   task automatic wait_out(input bit want_fault, input int budget, input string name);
      bit hit;
      hit = 0;
      for (int k = 0; k < budget && !hit; k++) begin
         @(negedge clock);
         hit = want_fault ? fault : locked;
      end
      n_checks++;
      if (!hit) begin
         n_errors++;
         $display("FAIL %s: got 0 expected 1 within %0d cycles", name, budget);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clock);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; enable = 1'b0; fault_clear = 1'b0;
      cyc(2);
      chk("rst_locked", int'(locked), 0);
      chk("rst_fault",  int'(fault), 0);
      chk("rst_lost",   int'(lost), 0);
      chk("rst_half",   int'(half_period), 0);
      #1 reset = 1'b0;

      cyc(20);
      chk("idle_locked", int'(locked), 0);

      enable = 1'b1;
      wait_out(1'b0, 80, "lock_h8");
      chk("lock_h8_half",  int'(half_period), 8);
      chk("lock_h8_fault", int'(fault), 0);

      cyc(10);
      fault_clear = 1'b1;
      cyc(1);
      fault_clear = 1'b0;
      chk("clear_ignored_locked", int'(locked), 1);

      mon_half = 0;
      wait_out(1'b1, 60, "stop_fault");
      chk("stop_lost",   int'(lost), 1);
      chk("stop_locked", int'(locked), 0);

      mon_half = 8;
      cyc(5);
      fault_clear = 1'b1;
      cyc(1);
      fault_clear = 1'b0;
      chk("clear_fault", int'(fault), 0);
      wait_out(1'b0, 80, "relock_h8");

      mon_half = 3;
      wait_out(1'b1, 30, "short_fault");
      chk("short_lost", int'(lost), 0);
      chk("short_half", int'(half_period), 3);

      fault_clear = 1'b1; enable = 1'b0;
      cyc(1);
      fault_clear = 1'b0;
      chk("dis_fault",  int'(fault), 0);
      chk("dis_locked", int'(locked), 0);
      chk("dis_half",   int'(half_period), 3);
      cyc(3);

      mon_half = 20; enable = 1'b1;
      cyc(150);
      chk("slow_locked", int'(locked), 0);
      chk("slow_fault",  int'(fault), 0);
      chk("slow_half",   int'(half_period), 20);

      mon_half = 8;
      wait_out(1'b0, 90, "relock_after_slow");
      chk("relock_half", int'(half_period), 8);

      cyc(7);
      #1 reset = 1'b1;
      #1;
      chk("async_rst_locked", int'(locked), 0);
      chk("async_rst_fault",  int'(fault), 0);
      chk("async_rst_lost",   int'(lost), 0);
      chk("async_rst_half",   int'(half_period), 0);
      cyc(1);
      #1 reset = 1'b0;
      cyc(5);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
